alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester 0/1 this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands per requester.
REQ-007 req0_sel / req1_sel  input  4  ALU operation code per requester (0000 add … 1011 lui).
REQ-008 alu_a, alu_b  output  32  operands to the shared combinational ALU.
REQ-009 alu_sel  output  4  operation code to the shared ALU.
REQ-010 alu_result  input  32  combinational ALU output (d_out).
REQ-011 rsp_valid  output  1  response holds a result.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_data  output  32  captured result.
REQ-014 rsp_id  output  1  requester that owns the response (0/1).
REQ-015 rsp_err  output  1  operation code was unsupported (1100-1111).
REQ-016 op_count  output  CNT_W  number of responses completed.

Function
REQ-017 FSM states IDLE, EXEC, RESP; the FSM SHALL be the only sequencing authority for the ALU.
REQ-018 IDLE: if any reqN_valid, assert exactly one reqN_ready combinationally, latch that requester's a/b/sel and id, go EXEC; else stay IDLE.
REQ-019 Handshake: transfer occurs only when reqN_valid and reqN_ready both high on a rising edge; reqN_ready SHALL be 0 in EXEC and RESP.
REQ-020 Arbitration: single valid requester wins; both valid -> requester not granted last wins (round-robin); after reset requester 0 has priority.
REQ-021 alu_a/alu_b/alu_sel SHALL always drive the latched operand registers (hold last values in IDLE/RESP).
REQ-022 EXEC (one cycle): capture alu_result into rsp_data, set rsp_err if latched sel >= 1100 with rsp_data forced to 0, go RESP.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_id/rsp_err stable until rsp_ready=1; on rsp_valid&rsp_ready go IDLE, increment op_count.
REQ-024 Latency: request accepted at edge N -> rsp_valid high from edge N+2; minimum 3 cycles per operation; a new request SHALL NOT be accepted in the same cycle a response completes.
REQ-025 rsp_valid SHALL be 0 outside RESP; rsp_data/rsp_id/rsp_err retain last value when rsp_valid=0.
REQ-026 op_count SHALL wrap from 2^CNT_W-1 to 0 without flagging; erroring responses are counted.
REQ-027 Requester dropping valid without a handshake SHALL have no effect; operands changing after acceptance SHALL not affect the result.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, round-robin pointer to "requester 0 preferred", and every output register to 0 (alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, rsp_err, op_count).
REQ-029 Reset in EXEC or RESP SHALL abandon the in-flight operation with no response and no count increment.
REQ-030 reqN_ready SHALL be 0 while rst_n=0.

Verification
REQ-031 Single op: req0 a=1, b=2, sel=0000 -> rsp_valid at accept+2, rsp_data=3, rsp_id=0, rsp_err=0, op_count=1.
REQ-032 Contention: both valid continuously, req0 sel=0001 (1-2), req1 sel=0010 (1<<2), rsp_ready=1 -> grants alternate 0,1,0,1; responses 0xFFFFFFFF, 4 alternating.
REQ-033 Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_data/rsp_id stable, both reqN_ready=0, then completion on rsp_ready=1.
REQ-034 Unsupported op: req1 sel=1101 -> rsp_err=1, rsp_data=0, rsp_id=1, op_count increments.
REQ-035 Reset mid-op: rst_n=0 during RESP -> next cycle all outputs 0, state IDLE, req0 wins next contention.
REQ-036 Counter wrap with CNT_W=2: five completed ops -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// one-cycle execute, and a held response until the consumer accepts it.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_sel,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_sel,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             pref_q, pref_d;
    logic             gnt_id_q, gnt_id_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt0, gnt1;

    always_comb begin
        state_d    = state_q;
        pref_d     = pref_q;
        gnt_id_d   = gnt_id_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state_q)
            IDLE: begin
                // pref_q=0 favours requester 0 when both are valid
                if (rst_n) begin
                    if (req0_valid && (!req1_valid || !pref_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0 || gnt1) begin
                    a_d      = gnt1 ? req1_a   : req0_a;
                    b_d      = gnt1 ? req1_b   : req0_b;
                    sel_d    = gnt1 ? req1_sel : req0_sel;
                    gnt_id_d = gnt1;
                    pref_d   = ~gnt1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_err_d  = (sel_q >= 4'd12);
                rsp_data_d = (sel_q >= 4'd12) ? 32'd0 : alu_result;
                rsp_id_d   = gnt_id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pref_q     <= 1'b0;
            gnt_id_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pref_q     <= pref_d;
            gnt_id_q   <= gnt_id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a 2-bit counter and a small behavioural ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [1:0]  op_count;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unsupported codes return garbage so the arbiter's zero-forcing is visible.
    always_comb begin
        alu_result = alu_a ^ alu_b;
        case (alu_sel)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a << alu_b[4:0];
            default: if (alu_sel >= 4'd12) alu_result = 32'hDEADBEEF;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Runs one operation from IDLE with requester inputs already driven.
    task automatic op(input int gid, input logic [31:0] exp_data, input int err,
                      input int cnt, input int bp, input int scramble);
        rsp_ready = (bp == 0);
        #1;
        chk("grant0", 32'(req0_ready), 32'(gid == 0));
        chk("grant1", 32'(req1_ready), 32'(gid == 1));
        @(posedge clk); #1;
        if (scramble != 0) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_a = 32'h55; req0_b = 32'h66;
            req1_a = 32'h77; req1_b = 32'h88;
        end
        chk("exec_valid", 32'(rsp_valid), 32'd0);
        chk("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_id", 32'(rsp_id), 32'(gid));
        chk("rsp_err", 32'(rsp_err), 32'(err));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, exp_data);
            chk("bp_id", 32'(rsp_id), 32'(gid));
            chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_valid", 32'(rsp_valid), 32'd0);
        chk("op_count", 32'(op_count), 32'(cnt));
        chk("data_hold", rsp_data, exp_data);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 32'd1; req0_b = 32'd2; req0_sel = 4'd0;
        req1_a = 32'd0; req1_b = 32'd0; req1_sel = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_data", rsp_data, 32'd0);

        // single op with operands changed and valid dropped after acceptance
        rst_n = 1'b1;
        op(0, 32'd3, 0, 1, 0, 1);

        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst2_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;

        // contention: grants alternate starting at requester 0
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd1; req0_b = 32'd2; req0_sel = 4'd1;
        req1_a = 32'd1; req1_b = 32'd2; req1_sel = 4'd2;
        op(0, 32'hFFFFFFFF, 0, 1, 0, 0);
        op(1, 32'd4, 0, 2, 0, 0);
        op(0, 32'hFFFFFFFF, 0, 3, 0, 0);
        op(1, 32'd4, 0, 0, 0, 0);

        // back-pressure, count wraps through to 1
        req1_valid = 1'b0;
        req0_a = 32'd5; req0_b = 32'd7; req0_sel = 4'd0;
        op(0, 32'd12, 0, 1, 5, 0);

        // unsupported op code
        req0_valid = 1'b0; req1_valid = 1'b1;
        req1_a = 32'd3; req1_b = 32'd4; req1_sel = 4'b1101;
        op(1, 32'd0, 1, 2, 0, 0);

        req1_valid = 1'b0; req0_valid = 1'b1;
        op(0, 32'd12, 0, 3, 0, 0);

        // reset while a response is held
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_a = 32'd1; req1_b = 32'd2; req1_sel = 4'd2;
        rsp_ready = 1'b0;
        #1;
        chk("mid_grant1", 32'(req1_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        chk("mid_resp", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(posedge clk); #1;
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_count", 32'(op_count), 32'd0);
        chk("mid_data", rsp_data, 32'd0);
        chk("mid_id_err", 32'({rsp_id, rsp_err}), 32'd0);
        chk("mid_alu", 32'({alu_sel, alu_a[27:0]}), 32'd0);
        rst_n = 1'b1;
        op(0, 32'd12, 0, 1, 0, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
